ysyx_24110015_idu_stage: RTL and testbench

//  Pipelined RV32I decode stage between IFU and EXU. Valid/ready on both sides.

---
 rtl/ysyx_24110015_idu_pkg.sv | 113 +++++++++++
 rtl/ysyx_24110015_idu_decode.sv | 187 ++++++++++++++++++
 rtl/ysyx_24110015_idu_stage.sv | 135 +++++++++++++
 tb/tb_ysyx_24110015_idu_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_idu_pkg.sv
// ysyx_24110015_idu_pkg
//   Shared definitions for the RV32I decode stage: opcode constants, ALU
//   operation codes, CSR operation codes, operand/next-pc source selects, the
//   decoded bundle type, the handshake state encoding and immediate helpers.
//
//   ALU op encoding (5 bits):
//     5'b0_0_fff  OP/OP-IMM with func3 fff (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND)
//     5'b0_1_fff  alternate forms: SUB (fff=000), SRA (fff=101)
//     5'h0F       illegal instruction marker
//     5'b1_0_fff  M extension with func3 fff (MUL .. REMU)
//     5'h18-5'h1D branch compares EQ, NE, LT, GE, LTU, GEU
package ysyx_24110015_idu_pkg;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // func7 values accepted on register-register / shift-immediate forms.
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Fully specified SYSTEM encodings.
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // ALU operation codes referenced by name.
  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_ILL  = 5'h0F;
  localparam logic [4:0] ALU_BEQ  = 5'h18;
  localparam logic [4:0] ALU_BNE  = 5'h19;
  localparam logic [4:0] ALU_BLT  = 5'h1A;
  localparam logic [4:0] ALU_BGE  = 5'h1B;
  localparam logic [4:0] ALU_BLTU = 5'h1C;
  localparam logic [4:0] ALU_BGEU = 5'h1D;

  // CSR operations.
  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;

  // ALU operand sources.
  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  // Decoded instruction bundle (everything except the pc).
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic        branch;
    logic        pc_a_sel;
    logic        pc_b_sel;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        illegal;
  } idu_bundle_t;

  // Handshake state, encoded as {out_v, skid_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } stage_state_t;

  // Sign-extended immediates for each instruction format.
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_24110015_idu_decode.sv
// ysyx_24110015_idu_decode
//   Purely combinational RV32I(+M, +SYSTEM/CSR) decoder: instruction word in,
//   decoded bundle out. Disabled or undecodable encodings set illegal and have
//   every side effect suppressed.
//   Parameters: EN_M   - decode MUL/DIV/REM, else flag them illegal.
//               EN_CSR - decode CSR ops, ecall and mret, else flag them illegal.
//   Ports: inst   (in, 32)          instruction word.
//          bundle (out, idu_bundle_t) decoded fields.
module ysyx_24110015_idu_decode
  import ysyx_24110015_idu_pkg::*;
#(
  parameter bit EN_M   = 1'b1,
  parameter bit EN_CSR = 1'b1
) (
  input  logic [31:0] inst,
  output idu_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  idu_bundle_t d;
  logic        ill;

  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer latches.
    d           = '0;
    d.rd        = inst[11:7];
    d.rs1       = inst[19:15];
    d.rs2       = inst[24:20];
    d.alu_op    = ALU_ADD;
    d.alu_a_sel = A_RS1;
    d.alu_b_sel = B_RS2;
    ill         = 1'b0;

    case (opcode)
      OPC_LUI: begin
        d.imm       = imm_u(inst);
        d.alu_a_sel = A_ZERO;
        d.alu_b_sel = B_IMM;
        d.reg_write = 1'b1;
      end

      OPC_AUIPC: begin
        d.imm       = imm_u(inst);
        d.alu_a_sel = A_PC;
        d.alu_b_sel = B_IMM;
        d.reg_write = 1'b1;
      end

      OPC_JAL: begin
        // Link value is pc+4 through the ALU; the target is pc+imm.
        d.imm       = imm_j(inst);
        d.alu_a_sel = A_PC;
        d.alu_b_sel = B_FOUR;
        d.reg_write = 1'b1;
        d.pc_b_sel  = 1'b1;
      end

      OPC_JALR: begin
        d.imm       = imm_i(inst);
        d.alu_a_sel = A_PC;
        d.alu_b_sel = B_FOUR;
        d.reg_write = 1'b1;
        d.pc_a_sel  = 1'b1;
        d.pc_b_sel  = 1'b1;
        ill         = (func3 != 3'b000);
      end

      OPC_BRANCH: begin
        d.imm      = imm_b(inst);
        d.branch   = 1'b1;
        d.pc_b_sel = 1'b1;
        case (func3)
          3'b000:  d.alu_op = ALU_BEQ;
          3'b001:  d.alu_op = ALU_BNE;
          3'b100:  d.alu_op = ALU_BLT;
          3'b101:  d.alu_op = ALU_BGE;
          3'b110:  d.alu_op = ALU_BLTU;
          3'b111:  d.alu_op = ALU_BGEU;
          default: ill      = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        d.imm       = imm_i(inst);
        d.alu_b_sel = B_IMM;
        d.mem_read  = 1'b1;
        d.mem_op    = func3;
        d.reg_write = 1'b1;
        ill         = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
      end

      OPC_STORE: begin
        d.imm       = imm_s(inst);
        d.alu_b_sel = B_IMM;
        d.mem_write = 1'b1;
        d.mem_op    = func3;
        ill         = (func3[2] == 1'b1) || (func3[1:0] == 2'b11);
      end

      OPC_OP_IMM: begin
        d.imm       = imm_i(inst);
        d.alu_b_sel = B_IMM;
        d.reg_write = 1'b1;
        d.alu_op    = {2'b00, func3};
        // Only the shift forms constrain the upper immediate bits.
        if (func3 == 3'b001) begin
          ill = (func7 != F7_ZERO);
        end else if (func3 == 3'b101) begin
          if (func7 == F7_ALT) d.alu_op = {2'b01, func3};
          else                 ill      = (func7 != F7_ZERO);
        end
      end

      OPC_OP: begin
        d.reg_write = 1'b1;
        case (func7)
          F7_ZERO: d.alu_op = {2'b00, func3};
          F7_ALT: begin
            d.alu_op = {2'b01, func3};
            ill      = (func3 != 3'b000) && (func3 != 3'b101);
          end
          F7_MUL: begin
            d.alu_op = {2'b10, func3};
            ill      = !EN_M;
          end
          default: ill = 1'b1;
        endcase
      end

      // fence / fence.i retire as no-ops.
      OPC_MISC_MEM: ;

      OPC_SYSTEM: begin
        case (func3)
          3'b000: begin
            if (EN_CSR && inst == INST_ECALL)     d.ecall  = 1'b1;
            else if (inst == INST_EBREAK)         d.ebreak = 1'b1;
            else if (EN_CSR && inst == INST_MRET) d.mret   = 1'b1;
            else                                  ill      = 1'b1;
          end
          3'b100: ill = 1'b1;
          default: begin
            // imm carries the CSR address; rs1 doubles as zimm when csr_imm.
            d.imm       = imm_i(inst);
            d.reg_write = 1'b1;
            d.csr_imm   = func3[2];
            case (func3[1:0])
              2'b01:   d.csr_op = CSR_RW;
              2'b10:   d.csr_op = CSR_RS;
              default: d.csr_op = CSR_RC;
            endcase
            ill = !EN_CSR;
          end
        endcase
      end

      default: ill = 1'b1;
    endcase

    if (ill) begin
      d.illegal   = 1'b1;
      d.alu_op    = ALU_ILL;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.branch    = 1'b0;
      d.csr_op    = CSR_NONE;
      d.csr_imm   = 1'b0;
      d.ecall     = 1'b0;
      d.ebreak    = 1'b0;
      d.mret      = 1'b0;
    end

    // Writes to x0 are discarded at the source.
    if (d.rd == 5'd0) d.reg_write = 1'b0;

    bundle = d;
  end

endmodule

// File: rtl/ysyx_24110015_idu_stage.sv
// ysyx_24110015_idu_stage
//   Pipelined decode stage between IFU and EXU. An output register plus a
//   one-entry skid register let in_ready come from registered state only, so
//   it never depends combinationally on out_ready. Order is preserved and a
//   synchronous flush drops everything held and the same-cycle input.
//   Parameters: XLEN (32 only), EN_M, EN_CSR (passed to the decoder).
//   Ports: clk, rst (async active-low), flush;
//          in_valid/in_ready/in_inst/in_pc from IFU;
//          out_valid/out_ready and the decoded bundle (out_pc .. out_illegal)
//          to EXU.
module ysyx_24110015_idu_stage
  import ysyx_24110015_idu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit EN_M   = 1'b1,
  parameter bit EN_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic [1:0]      out_alu_a_sel,
  output logic [1:0]      out_alu_b_sel,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [2:0]      out_mem_op,
  output logic            out_branch,
  output logic            out_pc_a_sel,
  output logic            out_pc_b_sel,
  output logic [1:0]      out_csr_op,
  output logic            out_csr_imm,
  output logic            out_ecall,
  output logic            out_ebreak,
  output logic            out_mret,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    idu_bundle_t     b;
  } slot_t;

  stage_state_t state;
  slot_t        out_q;
  slot_t        skid_q;
  slot_t        in_slot;
  idu_bundle_t  dec;
  logic         accept;

  ysyx_24110015_idu_decode #(
    .EN_M   (EN_M),
    .EN_CSR (EN_CSR)
  ) u_decode (
    .inst   (in_inst),
    .bundle (dec)
  );

  assign in_slot   = '{pc: in_pc, b: dec};
  assign in_ready  = !state[0];  // skid_v
  assign out_valid = state[1];   // out_v
  assign accept    = in_valid && in_ready && !flush;

  // NOTE: state and payload registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_q <= in_slot;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (accept) out_q <= in_slot;
            else        state <= ST_EMPTY;
          end else if (accept) begin
            // Output is stalled: park the new bundle behind it.
            skid_q <= in_slot;
            state  <= ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            out_q <= skid_q;
            state <= ST_FULL;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign out_pc        = out_q.pc;
  assign out_rd        = out_q.b.rd;
  assign out_rs1       = out_q.b.rs1;
  assign out_rs2       = out_q.b.rs2;
  assign out_imm       = out_q.b.imm;
  assign out_alu_op    = out_q.b.alu_op;
  assign out_alu_a_sel = out_q.b.alu_a_sel;
  assign out_alu_b_sel = out_q.b.alu_b_sel;
  assign out_reg_write = out_q.b.reg_write;
  assign out_mem_read  = out_q.b.mem_read;
  assign out_mem_write = out_q.b.mem_write;
  assign out_mem_op    = out_q.b.mem_op;
  assign out_branch    = out_q.b.branch;
  assign out_pc_a_sel  = out_q.b.pc_a_sel;
  assign out_pc_b_sel  = out_q.b.pc_b_sel;
  assign out_csr_op    = out_q.b.csr_op;
  assign out_csr_imm   = out_q.b.csr_imm;
  assign out_ecall     = out_q.b.ecall;
  assign out_ebreak    = out_q.b.ebreak;
  assign out_mret      = out_q.b.mret;
  assign out_illegal   = out_q.b.illegal;

endmodule

// File: tb/tb_ysyx_24110015_idu_stage.sv
// tb_ysyx_24110015_idu_stage
//   Directed bench for the decode stage. Two instances share the input side:
//   dut (EN_M=1) and dut_nm (EN_M=0). Inputs change 1 ns after the rising
//   edge and outputs are sampled at that same point.
module tb_ysyx_24110015_idu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_op;
  logic [1:0]  out_alu_a_sel, out_alu_b_sel, out_csr_op;
  logic [2:0]  out_mem_op;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch;
  logic        out_pc_a_sel, out_pc_b_sel, out_csr_imm;
  logic        out_ecall, out_ebreak, out_mret, out_illegal;

  logic        nm_in_ready, nm_out_valid;
  logic [31:0] nm_out_pc, nm_out_imm;
  logic [4:0]  nm_out_rd, nm_out_rs1, nm_out_rs2, nm_out_alu_op;
  logic [1:0]  nm_out_alu_a_sel, nm_out_alu_b_sel, nm_out_csr_op;
  logic [2:0]  nm_out_mem_op;
  logic        nm_out_reg_write, nm_out_mem_read, nm_out_mem_write, nm_out_branch;
  logic        nm_out_pc_a_sel, nm_out_pc_b_sel, nm_out_csr_imm;
  logic        nm_out_ecall, nm_out_ebreak, nm_out_mret, nm_out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_24110015_idu_stage #(.XLEN(32), .EN_M(1'b1), .EN_CSR(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_alu_a_sel(out_alu_a_sel), .out_alu_b_sel(out_alu_b_sel),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_op(out_mem_op), .out_branch(out_branch), .out_pc_a_sel(out_pc_a_sel),
    .out_pc_b_sel(out_pc_b_sel), .out_csr_op(out_csr_op), .out_csr_imm(out_csr_imm),
    .out_ecall(out_ecall), .out_ebreak(out_ebreak), .out_mret(out_mret),
    .out_illegal(out_illegal)
  );

  ysyx_24110015_idu_stage #(.XLEN(32), .EN_M(1'b0), .EN_CSR(1'b1)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nm_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_pc(nm_out_pc),
    .out_rd(nm_out_rd), .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2), .out_imm(nm_out_imm),
    .out_alu_op(nm_out_alu_op), .out_alu_a_sel(nm_out_alu_a_sel), .out_alu_b_sel(nm_out_alu_b_sel),
    .out_reg_write(nm_out_reg_write), .out_mem_read(nm_out_mem_read), .out_mem_write(nm_out_mem_write),
    .out_mem_op(nm_out_mem_op), .out_branch(nm_out_branch), .out_pc_a_sel(nm_out_pc_a_sel),
    .out_pc_b_sel(nm_out_pc_b_sel), .out_csr_op(nm_out_csr_op), .out_csr_imm(nm_out_csr_imm),
    .out_ecall(nm_out_ecall), .out_ebreak(nm_out_ebreak), .out_mret(nm_out_mret),
    .out_illegal(nm_out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    // ---- reset state ----
    step();
    step();
    check("rst out_valid", out_valid, 0);
    check("rst out_imm", out_imm, 0);
    check("rst out_alu_op", out_alu_op, 0);
    check("rst out_pc", out_pc, 0);
    rst = 1'b1;
    step();
    check("post-rst in_ready", in_ready, 1);
    check("post-rst out_valid", out_valid, 0);

    // ---- 1: addi x1,x0,5 ----
    out_ready = 1'b1;
    offer(32'h0050_0093, 32'h8000_0000);
    step();
    check("addi out_valid", out_valid, 1);
    check("addi pc", out_pc, 32'h8000_0000);
    check("addi rd", out_rd, 1);
    check("addi imm", out_imm, 5);
    check("addi alu_op", out_alu_op, 0);
    check("addi b_sel", out_alu_b_sel, 1);
    check("addi reg_write", out_reg_write, 1);

    // ---- 2: lui then sw back-to-back ----
    offer(32'h1234_52B7, 32'h8000_0004);
    step();
    check("lui out_valid", out_valid, 1);
    check("lui pc", out_pc, 32'h8000_0004);
    check("lui imm", out_imm, 32'h1234_5000);
    check("lui a_sel", out_alu_a_sel, 2);
    check("lui rd", out_rd, 5);
    offer(32'h0020_A423, 32'h8000_0008);
    step();
    check("sw out_valid", out_valid, 1);
    check("sw pc", out_pc, 32'h8000_0008);
    check("sw mem_write", out_mem_write, 1);
    check("sw imm", out_imm, 8);
    check("sw reg_write", out_reg_write, 0);
    check("sw mem_op", out_mem_op, 2);
    in_valid = 1'b0;
    step();
    check("drain out_valid", out_valid, 0);

    // ---- 3: stall with three offers ----
    out_ready = 1'b0;
    offer(32'h0010_0113, 32'h0000_0100);   // addi x2,x0,1
    step();
    check("stall A valid", out_valid, 1);
    check("stall A pc", out_pc, 32'h0000_0100);
    check("stall in_ready after A", in_ready, 1);
    offer(32'h0020_0193, 32'h0000_0104);   // addi x3,x0,2
    step();
    check("stall in_ready after B", in_ready, 0);
    check("stall A pc held", out_pc, 32'h0000_0100);
    offer(32'h0030_0213, 32'h0000_0108);   // addi x4,x0,3 (refused)
    step();
    check("stall in_ready still 0", in_ready, 0);
    check("stall A pc stable", out_pc, 32'h0000_0100);
    check("stall A rd stable", out_rd, 2);
    check("stall A imm stable", out_imm, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("release B valid", out_valid, 1);
    check("release B pc", out_pc, 32'h0000_0104);
    check("release B rd", out_rd, 3);
    check("release in_ready", in_ready, 1);
    step();
    check("release empty", out_valid, 0);

    // ---- 4: mul with and without M ----
    offer(32'h0220_81B3, 32'h0000_0010);
    step();
    check("mul alu_op", out_alu_op, 5'h10);
    check("mul illegal", out_illegal, 0);
    check("mul reg_write", out_reg_write, 1);
    check("noM mul illegal", nm_out_illegal, 1);
    check("noM mul reg_write", nm_out_reg_write, 0);
    check("noM mul alu_op", nm_out_alu_op, 5'h0F);
    in_valid = 1'b0;
    step();

    // ---- 5: flush while in SKID ----
    out_ready = 1'b0;
    offer(32'h0010_0113, 32'h0000_0200);
    step();
    offer(32'h0020_0193, 32'h0000_0204);
    step();
    check("pre-flush in_ready", in_ready, 0);
    offer(32'h0030_0213, 32'h0000_0208);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    check("flush out_valid", out_valid, 0);
    check("flush in_ready", in_ready, 1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("flush +1 out_valid", out_valid, 0);
    step();
    check("flush +2 out_valid", out_valid, 0);

    // ---- 6: branch, system, illegal, async reset ----
    offer(32'hFE20_8EE3, 32'h0000_0300);   // beq x1,x2,-4
    step();
    check("beq branch", out_branch, 1);
    check("beq imm", out_imm, 32'hFFFF_FFFC);
    check("beq alu_op", out_alu_op, 5'h18);
    check("beq reg_write", out_reg_write, 0);
    offer(32'h0010_0073, 32'h0000_0304);   // ebreak
    step();
    check("ebreak flag", out_ebreak, 1);
    check("ebreak illegal", out_illegal, 0);
    offer(32'hFFFF_FFFF, 32'h0000_0308);
    step();
    check("ones illegal", out_illegal, 1);
    check("ones alu_op", out_alu_op, 5'h0F);
    check("ones reg_write", out_reg_write, 0);
    offer(32'h0020_A063, 32'h0000_030C);   // branch func3=010
    step();
    check("br010 illegal", out_illegal, 1);
    check("br010 branch", out_branch, 0);
    offer(32'h0000_0073, 32'h0000_0310);   // ecall
    step();
    check("ecall flag", out_ecall, 1);
    check("ecall illegal", out_illegal, 0);
    offer(32'h3000_22F3, 32'h0000_0314);   // csrrs x5,mstatus,x0
    step();
    check("csrrs csr_op", out_csr_op, 2);
    check("csrrs reg_write", out_reg_write, 1);
    check("csrrs pc in order", out_pc, 32'h0000_0314);
    offer(32'h0050_0093, 32'h0000_0318);
    step();
    check("pre-reset out_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset pc", out_pc, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("after reset in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
